// File: rtl/block_check_sched.sv
`default_nettype none
// ============================================================================
// block_check_sched
//   Grants one whole message at a time to the shared BlockChecker, clears it,
//   streams the bytes gap-free and reports a tagged per-message verdict.
//   Option macro: BLK_SCHED_RR_EN (round-robin; fixed priority when undefined).
//   Revision: 1.0
// ============================================================================
module block_check_sched #(
    parameter int MAX_LEN = 255,
    parameter int LEN_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [7:0]       req0_data,
    input  logic             req0_last,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [7:0]       req1_data,
    input  logic             req1_last,
    output logic             req1_ready,
    output logic             chk_clr,
    output logic [7:0]       chk_in,
    input  logic             chk_result,
    output logic             grant,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic             done_ok,
    output logic             done_err,
    output logic [LEN_W-1:0] done_len
);

    localparam logic [LEN_W-1:0] c_MAX_LEN = LEN_W'(MAX_LEN);
    localparam logic [7:0]       c_SPACE   = 8'h20;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_STREAM = 2'd2,
        S_EVAL   = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_grant;
    logic [LEN_W-1:0] r_len;
    logic             r_err;
    logic             r_done;
    logic             r_done_id;
    logic             r_done_ok;
    logic             r_done_err;
    logic [LEN_W-1:0] r_done_len;

    logic             w_stream;
    logic             w_own_valid;
    logic [7:0]       w_own_data;
    logic             w_own_last;
    logic             w_pick;
    logic [LEN_W-1:0] w_len_inc;

    assign w_stream    = (r_state == S_STREAM);
    assign w_own_valid = r_grant ? req1_valid : req0_valid;
    assign w_own_data  = r_grant ? req1_data  : req0_data;
    assign w_own_last  = r_grant ? req1_last  : req0_last;
    assign w_len_inc   = r_len + LEN_W'(1);

`ifdef BLK_SCHED_RR_EN
    // On contention the requester that did not own the previous message wins.
    assign w_pick = (req0_valid && req1_valid) ? ~r_grant : req1_valid;
`else
    assign w_pick = ~req0_valid;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_grant    <= 1'b1;
            r_len      <= '0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
            r_done_id  <= 1'b0;
            r_done_ok  <= 1'b0;
            r_done_err <= 1'b0;
            r_done_len <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req0_valid || req1_valid) begin
                        r_grant <= w_pick;
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_len   <= '0;
                    r_err   <= 1'b0;
                    r_state <= S_STREAM;
                end
                S_STREAM: begin
                    // The checker cannot stall, so a missing byte aborts the message.
                    if (!w_own_valid) begin
                        r_err   <= 1'b1;
                        r_state <= S_EVAL;
                    end else begin
                        r_len <= w_len_inc;
                        if (w_own_last) begin
                            r_err   <= 1'b0;
                            r_state <= S_EVAL;
                        end else if (w_len_inc == c_MAX_LEN) begin
                            r_err   <= 1'b1;
                            r_state <= S_EVAL;
                        end
                    end
                end
                S_EVAL: begin
                    r_done     <= 1'b1;
                    r_done_id  <= r_grant;
                    r_done_ok  <= chk_result & ~r_err;
                    r_done_err <= r_err;
                    r_done_len <= r_len;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req0_ready = w_stream && !r_grant;
    assign req1_ready = w_stream &&  r_grant;
    assign chk_clr    = (r_state == S_CLEAR);
    assign chk_in     = (w_stream && w_own_valid) ? w_own_data : c_SPACE;
    assign grant      = r_grant;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign done_id    = r_done_id;
    assign done_ok    = r_done_ok;
    assign done_err   = r_done_err;
    assign done_len   = r_done_len;

endmodule
`default_nettype wire

// File: doc/block_check_sched.md
# block_check_sched

Message scheduler for the shared BlockChecker keyword-nesting datapath. Two character-stream requesters submit whole messages over valid/ready handshakes. The block grants one message at a time, clears the checker, and streams the granted message's bytes into it without gaps. It then samples the checker's balance result and returns a per-message completion pulse tagged with the requester id, verdict and length.

## Interface
- MAX_LEN, default 255: maximum accepted characters per message; must be in 1..255.
- LEN_W, default 8: width of the length counter and `done_len`.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester has a byte on its data bus.
- req0_data / req1_data  in  8  ASCII character.
- req0_last / req1_last  in  1  byte is the final character of its message.
- req0_ready / req1_ready  out  1  byte accepted this cycle when the requester's valid is also 1.
- chk_clr  out  1  synchronous clear to the checker's `reset` input.
- chk_in  out  8  character driven to the checker's `in` input.
- chk_result  in  1  checker balance flag (1 = balanced).
- grant  out  1  current or most recent owner id.
- busy  out  1  a message is in progress: state is not IDLE.
- done  out  1  one-cycle completion pulse.
- done_id  out  1  owner of the completed message.
- done_ok  out  1  message was balanced and well-formed.
- done_err  out  1  message was aborted.
- done_len  out  LEN_W  number of characters accepted.

## Operation
- States: IDLE, CLEAR, STREAM, EVAL.
- IDLE:
  - If any req_valid is 1, pick the owner, latch it into `grant`, and go to CLEAR. Otherwise stay.
  - No ready is asserted in IDLE.
- CLEAR:
  - chk_clr=1, chk_in=8'h20, both ready=0.
  - Length counter cleared to 0. Go to STREAM.
- STREAM:
  - Owner's ready=1; the other requester's ready=0.
  - chk_in is the owner's data.
  - Each handshake increments the length counter.
  - Handshake with last=1: go to EVAL with err=0.
  - Owner valid=0: gap, which is a protocol error. Drive chk_in=8'h20, set err=1, go to EVAL. The checker cannot stall, so gaps are forbidden.
  - Handshake without last when the counter reaches MAX_LEN: set err=1, go to EVAL.
- EVAL:
  - chk_in=8'h20. A space never changes the checker counters.
  - Register done_ok = chk_result & ~err, plus done_id, done_err and done_len. Pulse done for the next cycle, then go to IDLE.
- chk_in is 8'h20 in every state except STREAM with valid owner data.
- Arbitration happens only in IDLE. A message is never preempted.

## Timing
- Reset (reset=0, asynchronous):
  - state=IDLE, grant=1, so requester 0 wins first.
  - All ready, done, done_ok, done_err and chk_clr are 0; done_id=0, done_len=0, chk_in=8'h20, busy=0.
- Reset mid-message: abandon the message immediately with no done pulse. The next message gets its own CLEAR.
- Cycle timing:
  - Arbitration cycle t: IDLE.
  - t+1: CLEAR.
  - First byte can be accepted in t+2.
  - Final handshake in cycle k: EVAL in k+1, done=1 in k+2.
  - The done cycle is IDLE and may arbitrate concurrently, so the next CLEAR follows in k+3.
- An abort on a gap in cycle g gives done=1 in g+2 with done_err=1 and done_ok=0.
- done_* outputs hold their value until the next done pulse. done is high for exactly one cycle.
- A single-byte message (last on the first byte) is legal: done_len=1.

## Configuration
- Macro BLK_SCHED_RR_EN.
- Defined: round-robin. When both requesters are valid in IDLE, the requester that is not the current `grant` wins. A lone valid requester always wins.
- Undefined: fixed priority. Requester 0 wins whenever req0_valid=1. `grant` still records the owner.

## Test plan
- Req0 sends "begin end" contiguously, last on 'd':
  - chk_clr pulses once before the first byte.
  - done in the cycle two after 'd', with done_id=0, done_ok=1, done_err=0, done_len=9.
- Req1 sends "begin x":
  - done_id=1, done_ok=0, done_len=7.
- Both valid continuously, each sending "end begin" repeatedly:
  - With BLK_SCHED_RR_EN, grants alternate 0,1,0,1.
  - Without it, requester 0 always wins and req1_ready stays 0.
- Req0 drops valid after "beg":
  - done_err=1, done_ok=0, done_len=3.
  - The following balanced message from req1 reports done_ok=1, so the clear is effective.
- MAX_LEN=4, message "beginend" with no gaps:
  - Abort after 4 bytes: done_err=1, done_len=4, ready=0 from then on.
- reset=0 asserted mid-STREAM:
  - All outputs at their reset values asynchronously, no done pulse.
  - After release, requester 0 wins the first arbitration.
